// File: rtl/clk_div_ctrl.sv
// Run-time controller for a 2N clock divider: programmable half-period, glitch-free
// ratio changes at toggle boundaries, and clean start/stop with the output parking low.
module clk_div_ctrl #(
  parameter int W        = 8,
  parameter int DEF_HALF = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_half,
  output logic         cfg_ready,
  output logic         clk_div,
  output logic         rise_tick,
  output logic         fall_tick,
  output logic         busy,
  output logic         cfg_err
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [W-1:0] DEF = W'(DEF_HALF);

  state_t       state, state_nxt;
  logic [W-1:0] cnt, cnt_nxt;
  logic [W-1:0] active_half, half_nxt;
  logic [W-1:0] pend_half, ph_nxt;
  logic         pend_vld, pv_nxt;
  logic         div_nxt;
  logic         toggle;
  logic         xfer, cfg_bad, cfg_ok, bnd;

  assign cfg_ready = !pend_vld;
  assign busy      = (state != IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_bad   = xfer && (cfg_half == '0);
  assign cfg_ok    = xfer && (cfg_half != '0);
  assign bnd       = (cnt == active_half - W'(1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    div_nxt   = clk_div;
    half_nxt  = active_half;
    pv_nxt    = pend_vld;
    ph_nxt    = pend_half;
    toggle    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        div_nxt = 1'b0;
        // Pending left over from a stop taken in the same cycle as its transfer
        if (pend_vld) begin
          half_nxt = pend_half;
          pv_nxt   = 1'b0;
        end
        if (cfg_ok) half_nxt = cfg_half;
        if (en) state_nxt = RUN;
      end
      default: begin
        if (state == RUN && !en && !clk_div) begin
          // Low phase stop: output already parked, no toggle needed
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (pend_vld) begin
            half_nxt = pend_half;
            pv_nxt   = 1'b0;
          end
        end else begin
          if (bnd) begin
            toggle  = 1'b1;
            div_nxt = !clk_div;
            cnt_nxt = '0;
            if (pend_vld) begin
              half_nxt = pend_half;
              pv_nxt   = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + W'(1);
          end
          // Outside the low-phase exit, clk_div is 1 here whenever en==0
          if (en)       state_nxt = RUN;
          else if (bnd) state_nxt = IDLE;
          else          state_nxt = STOP;
        end
        if (cfg_ok) begin
          ph_nxt = cfg_half;
          pv_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      clk_div     <= 1'b0;
      active_half <= DEF;
      pend_half   <= '0;
      pend_vld    <= 1'b0;
      rise_tick   <= 1'b0;
      fall_tick   <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      clk_div     <= div_nxt;
      active_half <= half_nxt;
      pend_half   <= ph_nxt;
      pend_vld    <= pv_nxt;
      rise_tick   <= toggle && !clk_div;
      fall_tick   <= toggle && clk_div;
      cfg_err     <= cfg_bad;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: waveform patterns, config handshake, stop and reset sequencing.
module tb_clk_div_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, en, cfg_valid;
  logic [W-1:0] cfg_half;
  logic         cfg_ready, clk_div, rise_tick, fall_tick, busy, cfg_err;

  int total = 0;
  int bad   = 0;

  clk_div_ctrl #(.W(W), .DEF_HALF(3)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_half(cfg_half),
    .cfg_ready(cfg_ready), .clk_div(clk_div), .rise_tick(rise_tick),
    .fall_tick(fall_tick), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    reset = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    repeat (2) @(negedge clk);
  endtask

  // Shift n samples of clk_div/rise/fall in, oldest sample ends up as the MSB.
  task automatic capture(input int n, output logic [31:0] d, output logic [31:0] r,
                         output logic [31:0] f);
    d = '0; r = '0; f = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d = {d[30:0], clk_div};
      r = {r[30:0], rise_tick};
      f = {f[30:0], fall_tick};
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({clk_div, busy, cfg_ready, rise_tick, fall_tick, cfg_err} !== 6'b001000) begin
      bad++;
      $display("FAIL reset_outs: got %b want 001000",
               {clk_div, busy, cfg_ready, rise_tick, fall_tick, cfg_err});
    end
  endtask

  task automatic test_default_run();
    logic [31:0] d, r, f;
    do_reset();
    reset = 1'b1; en = 1'b1;
    capture(16, d, r, f);
    total++;
    if (d[15:0] !== 16'b0001110001110001) begin
      bad++; $display("FAIL def_clk_div: got %b want 0001110001110001", d[15:0]);
    end
    total++;
    if (r[15:0] !== 16'b0001000001000001) begin
      bad++; $display("FAIL def_rise: got %b want 0001000001000001", r[15:0]);
    end
    total++;
    if (f[15:0] !== 16'b0000001000001000) begin
      bad++; $display("FAIL def_fall: got %b want 0000001000001000", f[15:0]);
    end
  endtask

  // Continues from test_default_run: sitting in the first cycle of a high phase.
  task automatic test_cfg_change();
    logic [31:0] d, r, f;
    cfg_valid = 1'b1; cfg_half = 8'd5;
    capture(1, d, r, f);
    cfg_valid = 1'b0;
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++; $display("FAIL chg_ready_drop: got %b want 0", cfg_ready);
    end
    capture(1, d, r, f);
    total++;
    if (cfg_ready !== 1'b0 || clk_div !== 1'b1) begin
      bad++; $display("FAIL chg_ready_hold: got ready=%b div=%b want 0 1", cfg_ready, clk_div);
    end
    capture(22, d, r, f);
    total++;
    if (d[21:0] !== 22'b0000011111000001111100) begin
      bad++; $display("FAIL chg_clk_div: got %b want 0000011111000001111100", d[21:0]);
    end
    total++;
    if (r[21:0] !== 22'b0000010000000001000000) begin
      bad++; $display("FAIL chg_rise: got %b want 0000010000000001000000", r[21:0]);
    end
    total++;
    if (f[21:0] !== 22'b1000000000100000000010) begin
      bad++; $display("FAIL chg_fall: got %b want 1000000000100000000010", f[21:0]);
    end
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++; $display("FAIL chg_ready_back: got %b want 1", cfg_ready);
    end
  endtask

  task automatic test_stop();
    logic [31:0] d, r, f;
    do_reset();
    reset = 1'b1; en = 1'b1;
    capture(5, d, r, f);
    en = 1'b0;
    capture(1, d, r, f);
    total++;
    if (clk_div !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL stop_hold_high: got div=%b busy=%b want 1 1", clk_div, busy);
    end
    capture(1, d, r, f);
    total++;
    if ({clk_div, fall_tick, busy} !== 3'b010) begin
      bad++; $display("FAIL stop_fall: got %b want 010", {clk_div, fall_tick, busy});
    end
    capture(5, d, r, f);
    total++;
    if (d[4:0] !== 5'b0 || r[4:0] !== 5'b0 || f[4:0] !== 5'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL stop_parked: got d=%b r=%b f=%b busy=%b want all 0",
                      d[4:0], r[4:0], f[4:0], busy);
    end
    en = 1'b1;
    capture(2, d, r, f);
    total++;
    if (busy !== 1'b1 || clk_div !== 1'b0) begin
      bad++; $display("FAIL stop_restart: got busy=%b div=%b want 1 0", busy, clk_div);
    end
    en = 1'b0;
    capture(1, d, r, f);
    total++;
    if ({busy, clk_div, rise_tick, fall_tick} !== 4'b0000) begin
      bad++; $display("FAIL stop_low_phase: got %b want 0000",
                      {busy, clk_div, rise_tick, fall_tick});
    end
    capture(3, d, r, f);
    total++;
    if (d[2:0] !== 3'b0 || r[2:0] !== 3'b0 || f[2:0] !== 3'b0) begin
      bad++; $display("FAIL stop_low_quiet: got d=%b r=%b f=%b want 0", d[2:0], r[2:0], f[2:0]);
    end
  endtask

  task automatic test_cfg_err();
    logic [31:0] d, r, f;
    do_reset();
    reset = 1'b1; en = 1'b1;
    capture(2, d, r, f);
    cfg_valid = 1'b1; cfg_half = 8'd0;
    capture(1, d, r, f);
    cfg_valid = 1'b0;
    total++;
    if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      bad++; $display("FAIL err_pulse: got err=%b ready=%b want 1 1", cfg_err, cfg_ready);
    end
    capture(1, d, r, f);
    total++;
    if (cfg_err !== 1'b0 || clk_div !== 1'b1) begin
      bad++; $display("FAIL err_clear: got err=%b div=%b want 0 1", cfg_err, clk_div);
    end
    capture(11, d, r, f);
    total++;
    if (d[10:0] !== 11'b11000111000) begin
      bad++; $display("FAIL err_period: got %b want 11000111000", d[10:0]);
    end
  endtask

  task automatic test_half_one();
    logic [31:0] d, r, f;
    do_reset();
    reset = 1'b1; cfg_valid = 1'b1; cfg_half = 8'd1;
    capture(1, d, r, f);
    cfg_valid = 1'b0; en = 1'b1;
    total++;
    if ({busy, clk_div, cfg_ready} !== 3'b001) begin
      bad++; $display("FAIL h1_idle_load: got %b want 001", {busy, clk_div, cfg_ready});
    end
    capture(8, d, r, f);
    total++;
    if (d[7:0] !== 8'b01010101 || r[7:0] !== 8'b01010101 || f[7:0] !== 8'b00101010) begin
      bad++; $display("FAIL h1_toggle: got d=%b r=%b f=%b want 01010101 01010101 00101010",
                      d[7:0], r[7:0], f[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, r, f;
    do_reset();
    reset = 1'b1; en = 1'b1;
    capture(6, d, r, f);
    cfg_valid = 1'b1; cfg_half = 8'd2;
    capture(1, d, r, f);
    cfg_valid = 1'b0;
    total++;
    if (cfg_ready !== 1'b0 || clk_div !== 1'b0 || fall_tick !== 1'b1) begin
      bad++; $display("FAIL b2b_bnd_xfer: got ready=%b div=%b fall=%b want 0 0 1",
                      cfg_ready, clk_div, fall_tick);
    end
    capture(7, d, r, f);
    total++;
    if (d[6:0] !== 7'b0011001 || cfg_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_apply: got d=%b ready=%b want 0011001 1", d[6:0], cfg_ready);
    end
  endtask

  task automatic test_reset_mid_stop();
    logic [31:0] d, r, f;
    do_reset();
    reset = 1'b1; en = 1'b1;
    capture(4, d, r, f);
    en = 1'b0; cfg_valid = 1'b1; cfg_half = 8'd7;
    capture(1, d, r, f);
    cfg_valid = 1'b0;
    total++;
    if ({busy, cfg_ready, clk_div} !== 3'b101) begin
      bad++; $display("FAIL rst_stop_setup: got %b want 101", {busy, cfg_ready, clk_div});
    end
    reset = 1'b0;
    capture(1, d, r, f);
    total++;
    if ({clk_div, busy, cfg_ready, rise_tick, fall_tick} !== 5'b00100) begin
      bad++; $display("FAIL rst_stop_clear: got %b want 00100",
                      {clk_div, busy, cfg_ready, rise_tick, fall_tick});
    end
    reset = 1'b1; en = 1'b1;
    capture(16, d, r, f);
    total++;
    if (d[15:0] !== 16'b0001110001110001) begin
      bad++; $display("FAIL rst_stop_period: got %b want 0001110001110001", d[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_cfg_change();
    test_stop();
    test_cfg_err();
    test_half_one();
    test_back_to_back();
    test_reset_mid_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
